stream_demux_router: RTL

- Parametrised, registered successor to the interface unit's 3-way combinational demux.
- Steers a valid/ready input word stream from the input FIFO to one of NUM_CH consumer channels (filter, ifmap, psum, ...).
- Selection is held for a multi-beat burst. Each channel has its own registered output slot with backpressure.
- Out-of-range selects are flagged and discarded.
- Sits between the input FIFO read side and the GLB/PE-array loaders.

---
 rtl/stream_demux_router_pkg.sv | 16 +
 rtl/stream_demux_router_out_slot.sv | 32 +++
 rtl/stream_demux_router.sv | 102 ++++++++++
 3 files changed

// File: rtl/stream_demux_router_pkg.sv
// Shared definitions for the interface unit: channel IDs, router FSM state, default widths.
package stream_demux_router_pkg;

   localparam int CH_FILTER = 0;
   localparam int CH_IFMAP  = 1;
   localparam int CH_PSUM   = 2;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_LEN_WIDTH  = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } router_state_t;

endpackage

// File: rtl/stream_demux_router_out_slot.sv
// Single-entry valid/ready output register; a load wins over a drain in the same cycle.
module demux_out_slot
   import stream_demux_router_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  ready,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  can_load
);

   // Loading is safe when the slot is empty or its word leaves this cycle.
   assign can_load = !valid || ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux_router.sv
// Registered burst demux: steers a valid/ready word stream to one of NUM_CH output slots.
//
//   state | meaning
//   IDLE  | next input beat is a first beat; in_sel/in_len sampled on transfer
//   BURST | remaining beats go to the latched channel; rem counts beats left
module stream_demux_router
   import stream_demux_router_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_CH     = 3,
   parameter int SEL_WIDTH  = $clog2(NUM_CH),
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic [SEL_WIDTH-1:0]         in_sel,
   input  logic [LEN_WIDTH-1:0]         in_len,
   output logic [NUM_CH-1:0]            out_valid,
   input  logic [NUM_CH-1:0]            out_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic                         busy,
   output logic                         sel_err
);

   router_state_t          state;
   logic [SEL_WIDTH-1:0]   sel_q;
   logic [LEN_WIDTH-1:0]   rem;
   logic [SEL_WIDTH-1:0]   target;
   logic [NUM_CH-1:0]      dest;
   logic [NUM_CH-1:0]      can_load;
   logic [NUM_CH-1:0]      load;
   logic                   target_ok;
   logic                   fire;

   assign target = (state == IDLE) ? in_sel : sel_q;

   // One-hot decode; an out-of-range select decodes to all zeros.
   always_comb begin
      dest = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (target == SEL_WIDTH'(k)) dest[k] = 1'b1;
      end
   end

   assign target_ok = |dest;
   // Invalid targets always accept so their words are sunk.
   assign in_ready  = !reset && (!target_ok || |(dest & can_load));
   assign fire      = in_valid && in_ready;
   assign load      = fire ? dest : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         sel_q   <= '0;
         rem     <= '0;
         busy    <= 1'b0;
         sel_err <= 1'b0;
      end else begin
         sel_err <= 1'b0;
         if (fire) begin
            case (state)
               IDLE: begin
                  sel_q   <= in_sel;
                  rem     <= in_len;
                  sel_err <= !target_ok;
                  if (in_len != '0) begin
                     state <= BURST;
                     busy  <= 1'b1;
                  end
               end
               BURST: begin
                  rem <= rem - 1'b1;
                  if (rem == LEN_WIDTH'(1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_out_slot #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .load      (load[k]),
         .load_data (in_data),
         .ready     (out_ready[k]),
         .valid     (out_valid[k]),
         .data      (out_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .can_load  (can_load[k])
      );
   end

endmodule
